// File: rtl/sdpram_sync_fifo_pkg.sv
// Shared helpers for the sdpram_sync_fifo slice: depth derivation from the address width.
package sdpram_sync_fifo_pkg;

    function automatic int unsigned fifo_depth(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

endpackage

// File: rtl/sdpram_sync_fifo_if.sv
// FIFO user-side bus: write/read requests, read data, status and sticky error flags.
interface sdpram_sync_fifo_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 9
);
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic                  err_clr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   data_count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wr_en, wr_data, rd_en, err_clr,
        input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
               data_count, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en, err_clr,
        output rd_data, rd_valid, full, empty, almost_full, almost_empty,
               data_count, overflow, underflow
    );
endinterface

// File: rtl/sdpram_sync_core.sv
// Inferred simple dual-port RAM, read-first, with synchronous read and optional output register.
module sdpram_sync_core
    import sdpram_sync_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned OUTPUT_REG = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  rvalid_o
);
    localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] ram_q;
    logic                  ram_vld_q;

    always_ff @(posedge clk) begin
        if (we_i) mem[waddr_i] <= wdata_i;
    end

    // Read register only loads on a read so rd_data holds between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_q     <= '0;
            ram_vld_q <= 1'b0;
        end else begin
            ram_vld_q <= re_i;
            if (re_i) ram_q <= mem[raddr_i];
        end
    end

    generate
        if (OUTPUT_REG != 0) begin : g_oreg
            logic [DATA_WIDTH-1:0] out_q;
            logic                  out_vld_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    out_q     <= '0;
                    out_vld_q <= 1'b0;
                end else begin
                    out_vld_q <= ram_vld_q;
                    if (ram_vld_q) out_q <= ram_q;
                end
            end

            assign rdata_o  = out_q;
            assign rvalid_o = out_vld_q;
        end else begin : g_noreg
            assign rdata_o  = ram_q;
            assign rvalid_o = ram_vld_q;
        end
    endgenerate

endmodule

// File: rtl/sdpram_sync_fifo.sv
// Single-clock FIFO over sdpram_sync_core: pointers, occupancy, registered flags, sticky errors.
module sdpram_sync_fifo
    import sdpram_sync_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 16,
    parameter int unsigned ADDR_WIDTH      = 9,
    parameter int unsigned OUTPUT_REG      = 0,
    parameter int unsigned ALMOST_FULL_TH  = (32'd1 << ADDR_WIDTH) - 32'd4,
    parameter int unsigned ALMOST_EMPTY_TH = 4
) (
    input logic               clk,
    input logic               rst,
    sdpram_sync_fifo_if.slave bus
);
    localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);
    localparam int unsigned CNT_W = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(ALMOST_FULL_TH);
    localparam logic [CNT_W-1:0] AE_C    = CNT_W'(ALMOST_EMPTY_TH);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  full_q, empty_q, afull_q, aempty_q;
    logic                  ovf_q, ovf_d, udf_q, udf_d;
    logic                  wr_acc, rd_acc;

    // Acceptance uses only the registered flags: no write-through on a full FIFO.
    assign wr_acc = bus.wr_en & ~full_q;
    assign rd_acc = bus.rd_en & ~empty_q;

    always_comb begin
        count_d = count_q;
        if (wr_acc && !rd_acc)      count_d = count_q + CNT_W'(1);
        else if (!wr_acc && rd_acc) count_d = count_q - CNT_W'(1);
    end

    // A new error in the same cycle as err_clr keeps the flag set.
    assign ovf_d = (bus.wr_en & full_q)  | (ovf_q & ~bus.err_clr);
    assign udf_d = (bus.rd_en & empty_q) | (udf_q & ~bus.err_clr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr_q <= wr_ptr_q + ADDR_WIDTH'(1);
            if (rd_acc) rd_ptr_q <= rd_ptr_q + ADDR_WIDTH'(1);
            count_q  <= count_d;
            full_q   <= (count_d == DEPTH_C);
            empty_q  <= (count_d == '0);
            afull_q  <= (count_d >= AF_C);
            aempty_q <= (count_d <= AE_C);
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    sdpram_sync_core #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .OUTPUT_REG(OUTPUT_REG)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .we_i     (wr_acc),
        .waddr_i  (wr_ptr_q),
        .wdata_i  (bus.wr_data),
        .re_i     (rd_acc),
        .raddr_i  (rd_ptr_q),
        .rdata_o  (bus.rd_data),
        .rvalid_o (bus.rd_valid)
    );

    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = afull_q;
    assign bus.almost_empty = aempty_q;
    assign bus.data_count   = count_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;

endmodule

// File: tb/tb_sdpram_sync_fifo.sv
// Queue-model scoreboard bench driving OUTPUT_REG=0 and OUTPUT_REG=1 instances in lockstep.
module tb_sdpram_sync_fifo;
    localparam int DW = 16, AW = 4, DEPTH = 16, AF = 12, AE = 4;

    logic clk = 1'b0;
    logic rst;
    logic wr_en, rd_en, err_clr;
    logic [DW-1:0] wr_data;

    always #5 clk = ~clk;

    sdpram_sync_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus0();
    sdpram_sync_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1();

    assign bus0.wr_en = wr_en;  assign bus0.wr_data = wr_data;
    assign bus0.rd_en = rd_en;  assign bus0.err_clr = err_clr;
    assign bus1.wr_en = wr_en;  assign bus1.wr_data = wr_data;
    assign bus1.rd_en = rd_en;  assign bus1.err_clr = err_clr;

    sdpram_sync_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUTPUT_REG(0),
                       .ALMOST_FULL_TH(AF), .ALMOST_EMPTY_TH(AE))
        dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
    sdpram_sync_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUTPUT_REG(1),
                       .ALMOST_FULL_TH(AF), .ALMOST_EMPTY_TH(AE))
        dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    typedef struct {
        logic [DW-1:0] d;
        int            due;
    } exp_t;

    exp_t          sb0[$], sb1[$];
    exp_t          e0, e1;
    logic [DW-1:0] mq[$];
    logic          m_ovf, m_udf;
    int            cyc = 0;
    int            n_tests = 0, n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_dut(input string t, input logic [AW:0] cnt, input logic f, input logic e,
                             input logic af, input logic ae, input logic o, input logic u);
        int n;
        n = mq.size();
        chk({t, "count"},        32'(cnt), 32'(n));
        chk({t, "full"},         32'(f),   32'(n == DEPTH));
        chk({t, "empty"},        32'(e),   32'(n == 0));
        chk({t, "almost_full"},  32'(af),  32'(n >= AF));
        chk({t, "almost_empty"}, 32'(ae),  32'(n <= AE));
        chk({t, "overflow"},     32'(o),   32'(m_ovf));
        chk({t, "underflow"},    32'(u),   32'(m_udf));
    endtask

    task automatic check_all();
        check_dut("d0.", bus0.data_count, bus0.full, bus0.empty, bus0.almost_full,
                  bus0.almost_empty, bus0.overflow, bus0.underflow);
        check_dut("d1.", bus1.data_count, bus1.full, bus1.empty, bus1.almost_full,
                  bus1.almost_empty, bus1.overflow, bus1.underflow);
    endtask

    // One clock of stimulus; the model is applied to the pre-edge occupancy.
    task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
        logic          was_full, was_empty;
        logic [DW-1:0] x;
        wr_en = w; wr_data = d; rd_en = r; err_clr = c;
        @(posedge clk);
        #1;
        was_full  = (mq.size() == DEPTH);
        was_empty = (mq.size() == 0);
        if (r && !was_empty) begin
            x = mq.pop_front();
            sb0.push_back('{d: x, due: cyc});
            sb1.push_back('{d: x, due: cyc + 1});
        end
        if (w && !was_full) mq.push_back(d);
        m_ovf = (w && was_full)  || (m_ovf && !c);
        m_udf = (r && was_empty) || (m_udf && !c);
        check_all();
    endtask

    task automatic assert_reset();
        rst = 1'b1;
        wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; wr_data = '0;
        #1;
        mq.delete(); sb0.delete(); sb1.delete();
        m_ovf = 1'b0; m_udf = 1'b0;
        check_all();
        chk("d0.rst_rd_valid", 32'(bus0.rd_valid), 32'd0);
        chk("d1.rst_rd_valid", 32'(bus1.rd_valid), 32'd0);
        chk("d0.rst_rd_data",  32'(bus0.rd_data),  32'd0);
        chk("d1.rst_rd_data",  32'(bus1.rd_data),  32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (bus0.rd_valid) begin
            if (sb0.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL d0.rd_valid: unexpected word 0x%0h, none outstanding", bus0.rd_data);
            end else begin
                e0 = sb0.pop_front();
                chk("d0.rd_data", 32'(bus0.rd_data), 32'(e0.d));
                chk("d0.rd_latency", 32'(cyc), 32'(e0.due));
            end
        end
    end

    always @(negedge clk) begin
        if (bus1.rd_valid) begin
            if (sb1.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL d1.rd_valid: unexpected word 0x%0h, none outstanding", bus1.rd_data);
            end else begin
                e1 = sb1.pop_front();
                chk("d1.rd_data", 32'(bus1.rd_data), 32'(e1.d));
                chk("d1.rd_latency", 32'(cyc), 32'(e1.due));
            end
        end
    end

    initial begin
        assert_reset();

        // Fill to full, then one rejected write.
        for (int i = 0; i < 16; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
        step(1'b1, 16'hDEAD, 1'b0, 1'b0);

        // Drain in order, then let the pipelines empty out.
        for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0);

        // Empty with both requests, then read the word back.
        step(1'b1, 16'h1234, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);

        // Full with both requests.
        for (int i = 0; i < 16; i++) step(1'b1, 16'($urandom), 1'b0, 1'b0);
        step(1'b1, 16'hBEEF, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);

        // Sustained streaming at occupancy 8; pointers wrap repeatedly.
        while (mq.size() > 8) step(1'b0, '0, 1'b1, 1'b0);
        while (mq.size() < 8) step(1'b1, 16'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) step(1'b1, 16'($urandom), 1'b1, 1'b0);

        // Random traffic, including errors coinciding with err_clr.
        for (int i = 0; i < 400; i++) begin
            int mode;
            mode = (i / 50) % 3;
            step(1'(($urandom % 4) < (mode == 0 ? 3 : (mode == 1 ? 1 : 2))),
                 16'($urandom),
                 1'(($urandom % 4) < (mode == 0 ? 1 : (mode == 1 ? 3 : 2))),
                 1'(($urandom % 16) == 0));
        end

        // Reset mid-stream with reads in flight.
        for (int i = 0; i < 6; i++) step(1'b1, 16'($urandom), 1'b0, 1'b0);
        step(1'b1, 16'($urandom), 1'b1, 1'b0);
        assert_reset();

        for (int i = 0; i < 60; i++)
            step(1'($urandom % 2), 16'($urandom), 1'($urandom % 2), 1'(($urandom % 20) == 0));
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b0);

        chk("d0.outstanding", 32'(sb0.size()), 32'd0);
        chk("d1.outstanding", 32'(sb1.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
